fft_result_buffer: RTL and testbench

- Sits directly downstream of the FFT core and captures its output stream (out_valid, dout_r, dout_i) into an internal N-entry complex buffer.
- Exposes the buffer plus control/status registers to the RS5 core as a memory-mapped peripheral on the same data bus style as the RAM/PLIC/RTC (en/we/addr/data, 1-cycle read latency).
- Raises a level interrupt when a full frame is captured, so software need not poll the accelerator.

---
 rtl/fft_result_buffer.sv | 206 ++++++++++++++++++++
 tb/tb_fft_result_buffer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_result_buffer.sv
// fft_result_buffer
//   Captures one frame of complex FFT output samples into an internal
//   N_POINTS-entry buffer and exposes it, together with control/status
//   registers, as a memory-mapped bus peripheral (1-cycle registered reads).
//   A level interrupt is raised when a full frame has been captured.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   in_valid          sample strobe from the FFT core
//   din_r, din_i      real / imaginary sample components (stored raw)
//   en_i, we_i        bus select and byte write enables (we_i == 0 is a read)
//   addr_i, data_i    byte address and write data
//   data_o            registered read data, held when not reading
//   irq_o             frame-done interrupt (done & IRQ_EN)
//
// Register map (word aligned)
//   0x000 CTRL    bit0 ARM (pulse), bit1 CLEAR (pulse), bit2 IRQ_EN
//   0x004 STATUS  bit0 busy, bit1 done (W1C), bit2 overflow (W1C),
//                 bits[26:16] wr_ptr
//   0x400+4k      DATA[k] = {real[15:0], imag[15:0]}
module fft_result_buffer #(
  parameter int N_POINTS    = 64,
  parameter int DATA_WIDTH  = 16,
  parameter int BIT_REVERSE = 0,
  parameter int ADDR_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] din_r,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  en_i,
  input  logic [3:0]            we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           data_i,
  output logic [31:0]           data_o,
  output logic                  irq_o
);

  localparam int IDX_W = $clog2(N_POINTS);
  localparam int PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  function automatic logic [IDX_W-1:0] bit_rev(input logic [IDX_W-1:0] v);
    logic [IDX_W-1:0] r;
    for (int b = 0; b < IDX_W; b++) r[b] = v[IDX_W-1-b];
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              irq_en_q, irq_en_d;
  logic [31:0]       data_q, data_d;

  logic [31:0]       mem [N_POINTS];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [31:0]       mem_wdata;

  logic [31:0]       word_addr;
  logic              ctrl_sel, status_sel, data_sel;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_en, ctrl_wr, status_wr, arm, clear;
  logic [15:0]       r16, i16;
  logic [10:0]       ptr11;
  logic [31:0]       rd_val;
  logic              unused_bits;

  // Byte-lane and low address bits carry no meaning for this block.
  assign unused_bits = ^{addr_i[1:0], we_i[3:1], data_i[31:3]};

  // Address decode / bus strobes
  assign word_addr  = 32'(addr_i[ADDR_WIDTH-1:2]);
  assign ctrl_sel   = (word_addr == 32'd0);
  assign status_sel = (word_addr == 32'd1);
  assign data_sel   = (word_addr >= 32'h100) && (word_addr < 32'h100 + 32'(N_POINTS));
  assign rd_idx     = IDX_W'(word_addr - 32'h100);
  assign rd_en      = en_i && (we_i == 4'b0000);
  assign ctrl_wr    = en_i && we_i[0] && ctrl_sel;
  assign status_wr  = en_i && we_i[0] && status_sel;
  assign arm        = ctrl_wr && data_i[0];
  assign clear      = ctrl_wr && data_i[1];

  // Sample packing: each component zero-padded to 16 bits, no sign extension.
  always_comb begin
    r16 = '0;
    i16 = '0;
    r16[DATA_WIDTH-1:0] = din_r;
    i16[DATA_WIDTH-1:0] = din_i;
  end

  assign mem_wdata = {r16, i16};
  assign mem_waddr = (BIT_REVERSE != 0) ? bit_rev(wr_ptr_q[IDX_W-1:0])
                                        : wr_ptr_q[IDX_W-1:0];

  // Capture FSM and register updates. Flag clears from STATUS W1C are applied
  // first so that an event in the same cycle (done/overflow) still sets them.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    mem_we   = 1'b0;

    if (ctrl_wr) irq_en_d = data_i[2];
    if (status_wr) begin
      if (data_i[1]) done_d = 1'b0;
      if (data_i[2]) ovf_d  = 1'b0;
    end

    if (clear) begin
      // CLEAR wins over ARM and over a concurrent sample store.
      state_d  = S_IDLE;
      wr_ptr_d = '0;
      done_d   = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_d  = S_ARMED;
            wr_ptr_d = '0;
            done_d   = 1'b0;
            ovf_d    = 1'b0;
          end
        end
        S_ARMED, S_CAPTURE: begin
          if (in_valid) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (wr_ptr_q == PTR_W'(N_POINTS - 1)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_CAPTURE;
            end
          end
        end
        S_DONE: begin
          if (arm) begin
            state_d  = S_ARMED;
            wr_ptr_d = '0;
            done_d   = 1'b0;
            ovf_d    = 1'b0;
          end else if (in_valid) begin
            ovf_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Read mux; data_o holds its value unless a read is issued.
  assign ptr11 = 11'(wr_ptr_q);

  always_comb begin
    rd_val = '0;
    if (ctrl_sel) begin
      rd_val = {29'b0, irq_en_q, 2'b00};
    end else if (status_sel) begin
      rd_val = {5'b0, ptr11, 13'b0, ovf_q, done_q,
                (state_q == S_ARMED) || (state_q == S_CAPTURE)};
    end else if (data_sel) begin
      rd_val = mem[rd_idx];
    end
    data_d = rd_en ? rd_val : data_q;
  end

  // Control and read-data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      data_q   <= data_d;
    end
  end

  // Sample buffer: not reset; a read in the same cycle sees the old entry.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
  end

  assign data_o = data_q;
  assign irq_o  = done_q & irq_en_q;

endmodule

// File: tb/tb_fft_result_buffer.sv
module tb_fft_result_buffer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid;
  logic [15:0] din_r, din_i;
  logic        en_i;
  logic [3:0]  we_i;
  logic [11:0] addr_i;
  logic [31:0] data_i, data_o;
  logic        irq_o;

  logic        b_in_valid;
  logic [15:0] b_din_r, b_din_i;
  logic        b_en_i;
  logic [3:0]  b_we_i;
  logic [11:0] b_addr_i;
  logic [31:0] b_data_i, b_data_o;
  logic        b_irq_o;

  fft_result_buffer #(.N_POINTS(64), .DATA_WIDTH(16), .BIT_REVERSE(0), .ADDR_WIDTH(12)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
    .en_i(en_i), .we_i(we_i), .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .irq_o(irq_o)
  );

  fft_result_buffer #(.N_POINTS(8), .DATA_WIDTH(16), .BIT_REVERSE(1), .ADDR_WIDTH(12)) u_br (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .din_r(b_din_r), .din_i(b_din_i),
    .en_i(b_en_i), .we_i(b_we_i), .addr_i(b_addr_i), .data_i(b_data_i), .data_o(b_data_o),
    .irq_o(b_irq_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: expected buffer contents and software-visible flags.
  logic [31:0] m_mem [64];
  logic        m_irq_en;
  logic [31:0] m_status;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [11:0] a, input logic [31:0] d);
    en_i = 1'b1; we_i = 4'hF; addr_i = a; data_i = d;
    tick();
    en_i = 1'b0; we_i = 4'h0; data_i = '0;
  endtask

  task automatic bus_rd(input logic [11:0] a, output logic [31:0] d);
    en_i = 1'b1; we_i = 4'h0; addr_i = a;
    tick();
    en_i = 1'b0;
    d = data_o;
  endtask

  task automatic b_rd(input logic [11:0] a, output logic [31:0] d);
    b_en_i = 1'b1; b_we_i = 4'h0; b_addr_i = a;
    tick();
    b_en_i = 1'b0;
    d = b_data_o;
  endtask

  function automatic logic [31:0] st(input int ptr, input bit ovf, input bit dn, input bit busy);
    return (32'(ptr) << 16) | (32'(ovf) << 2) | (32'(dn) << 1) | 32'(busy);
  endfunction

  function automatic logic [31:0] model_read(input int w);
    if (w == 0) return {29'b0, m_irq_en, 2'b00};
    if (w == 1) return m_status;
    if (w >= 'h100 && w < 'h140) return m_mem[w - 'h100];
    return 32'h0;
  endfunction

  initial begin
    logic [31:0] d, hold;
    int stores, extra, cyc;

    reset = 1'b1; in_valid = 1'b0; din_r = '0; din_i = '0;
    en_i = 1'b0; we_i = '0; addr_i = '0; data_i = '0;
    b_in_valid = 1'b0; b_din_r = '0; b_din_i = '0;
    b_en_i = 1'b0; b_we_i = '0; b_addr_i = '0; b_data_i = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    chk("rst_data_o", data_o, 32'h0);
    chk("rst_irq", {31'b0, irq_o}, 32'h0);
    chk("rst_br_data_o", b_data_o, 32'h0);
    bus_rd(12'h004, d); chk("rst_status", d, 32'h0);
    bus_rd(12'h000, d); chk("rst_ctrl", d, 32'h0);

    // Continuous frame with IRQ_EN
    bus_wr(12'h000, 32'h5);
    bus_rd(12'h004, d); chk("armed_status", d, 32'h1);
    for (int k = 0; k < 64; k++) begin
      in_valid = 1'b1; din_r = 16'(k); din_i = 16'hFF00 + 16'(k);
      m_mem[k] = {16'(k), 16'hFF00 + 16'(k)};
      tick();
      if (k == 62) chk("irq_before_last", {31'b0, irq_o}, 32'h0);
    end
    in_valid = 1'b0;
    chk("irq_after_last", {31'b0, irq_o}, 32'h1);

    vecs[0] = '{12'h414, 32'h0005FF05};
    vecs[1] = '{12'h004, 32'h00400002};
    vecs[2] = '{12'h000, 32'h00000004};
    vecs[3] = '{12'h400, 32'h0000FF00};
    vecs[4] = '{12'h4FC, 32'h003FFF3F};
    vecs[5] = '{12'h500, 32'h00000000};
    vecs[6] = '{12'h008, 32'h00000000};
    vecs[7] = '{12'h0FC, 32'h00000000};
    vecs[8] = '{12'h417, 32'h0005FF05};
    for (int v = 0; v < 9; v++) begin
      bus_rd(vecs[v].addr, d);
      chk($sformatf("vec%0d_addr%03h", v, vecs[v].addr), d, vecs[v].exp);
    end

    // data_o held on idle and on writes; DATA writes ignored
    hold = data_o;
    tick();
    chk("hold_idle", data_o, hold);
    bus_wr(12'h414, 32'h12345678);
    chk("hold_write", data_o, hold);
    bus_rd(12'h414, d); chk("data_write_ignored", d, 32'h0005FF05);

    // Overflow in DONE
    in_valid = 1'b1; din_r = 16'hAAAA; din_i = 16'h5555;
    tick();
    in_valid = 1'b0;
    bus_rd(12'h004, d); chk("ovf_status", d, 32'h00400006);
    bus_rd(12'h400, d); chk("ovf_data0_kept", d, 32'h0000FF00);

    // W1C
    bus_wr(12'h004, 32'h2);
    chk("w1c_irq_low", {31'b0, irq_o}, 32'h0);
    bus_rd(12'h004, d); chk("w1c_done", d, 32'h00400004);
    bus_wr(12'h004, 32'h4);
    bus_rd(12'h004, d); chk("w1c_ovf", d, 32'h00400000);

    // Toggled in_valid, random data, re-arm from DONE
    bus_wr(12'h000, 32'h5);
    bus_rd(12'h004, d); chk("rearm_status", d, 32'h1);
    for (int c = 0; c < 128; c++) begin
      if (c % 2 == 0) begin
        in_valid = 1'b1; din_r = 16'($urandom); din_i = 16'($urandom);
        m_mem[c / 2] = {din_r, din_i};
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c == 125) chk("tog_irq_63", {31'b0, irq_o}, 32'h0);
    end
    in_valid = 1'b0;
    chk("tog_irq_64", {31'b0, irq_o}, 32'h1);
    bus_rd(12'h004, d); chk("tog_status", d, 32'h00400002);
    for (int j = 0; j < 64; j++) begin
      bus_rd(12'h400 + 12'(4 * j), d);
      chk($sformatf("tog_data%0d", j), d, m_mem[j]);
    end
    bus_wr(12'h000, 32'h0);
    chk("irqen_off_irq", {31'b0, irq_o}, 32'h0);
    bus_rd(12'h004, d); chk("irqen_off_status", d, 32'h00400002);

    // Random gaps, random extra samples, random bus reads against the model
    bus_wr(12'h000, 32'h1);
    stores = 0; cyc = 0;
    while (stores < 64 && cyc < 2000) begin
      if ($urandom_range(0, 2) != 0) begin
        in_valid = 1'b1; din_r = 16'($urandom); din_i = 16'($urandom);
        m_mem[stores] = {din_r, din_i};
        stores++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("rnd_frame_len", 32'(stores), 32'd64);
    extra = $urandom_range(0, 2);
    for (int e = 0; e < extra; e++) begin
      in_valid = 1'b1; din_r = 16'hDEAD; din_i = 16'hBEEF;
      tick();
      in_valid = 1'b0;
      tick();
    end
    m_irq_en = 1'b0;
    m_status = st(64, extra > 0, 1'b1, 1'b0);
    chk("rnd_irq", {31'b0, irq_o}, 32'h0);
    for (int n = 0; n < 24; n++) begin
      int w;
      w = (n < 2) ? n : int'($urandom_range(0, 'h150));
      bus_rd(12'(w * 4) | 12'($urandom_range(0, 3)), d);
      chk($sformatf("rnd_rd_w%03h", w), d, model_read(w));
    end

    // CLEAR (with ARM) mid-capture at wr_ptr=20
    bus_wr(12'h000, 32'h1);
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; din_r = 16'h0100 + 16'(k); din_i = 16'(k);
      m_mem[k] = {16'h0100 + 16'(k), 16'(k)};
      tick();
    end
    in_valid = 1'b0;
    bus_rd(12'h004, d); chk("mid_status", d, 32'h00140001);
    bus_wr(12'h000, 32'h3);
    bus_rd(12'h004, d); chk("clr_status", d, 32'h0);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; din_r = 16'hDEAD; din_i = 16'hDEAD;
      tick();
    end
    in_valid = 1'b0;
    bus_rd(12'h004, d); chk("clr_idle_status", d, 32'h0);
    bus_rd(12'h400, d); chk("clr_data0", d, m_mem[0]);
    bus_rd(12'h450, d); chk("clr_data20", d, m_mem[20]);

    // Read-before-write, then reset mid-capture at wr_ptr=30
    bus_wr(12'h000, 32'h5);
    in_valid = 1'b1; din_r = 16'h0777; din_i = 16'h0888;
    en_i = 1'b1; we_i = 4'h0; addr_i = 12'h400;
    tick();
    en_i = 1'b0;
    chk("rbw_old", data_o, m_mem[0]);
    m_mem[0] = 32'h07770888;
    for (int k = 1; k < 30; k++) begin
      din_r = 16'h0200 + 16'(k); din_i = 16'(k);
      m_mem[k] = {16'h0200 + 16'(k), 16'(k)};
      tick();
    end
    in_valid = 1'b0;
    bus_rd(12'h004, d); chk("pre_rst_status", d, 32'h001E0001);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_data_o", data_o, 32'h0);
    chk("mrst_irq", {31'b0, irq_o}, 32'h0);
    bus_rd(12'h004, d); chk("mrst_status", d, 32'h0);
    bus_rd(12'h000, d); chk("mrst_ctrl", d, 32'h0);
    bus_rd(12'h400, d); chk("mrst_stale0", d, 32'h07770888);
    bus_wr(12'h000, 32'h1);
    for (int k = 0; k < 64; k++) begin
      in_valid = 1'b1; din_r = 16'(3 * k); din_i = ~16'(k);
      m_mem[k] = {16'(3 * k), ~16'(k)};
      tick();
    end
    in_valid = 1'b0;
    bus_rd(12'h004, d); chk("fresh_status", d, 32'h00400002);
    chk("fresh_irq", {31'b0, irq_o}, 32'h0);
    for (int j = 0; j < 64; j += 9) begin
      bus_rd(12'h400 + 12'(4 * j), d);
      chk($sformatf("fresh_data%0d", j), d, m_mem[j]);
    end

    // BIT_REVERSE instance, N_POINTS=8
    b_en_i = 1'b1; b_we_i = 4'hF; b_addr_i = 12'h000; b_data_i = 32'h1;
    tick();
    b_en_i = 1'b0; b_we_i = 4'h0;
    for (int k = 0; k < 8; k++) begin
      b_in_valid = 1'b1; b_din_r = 16'(k); b_din_i = 16'h0050 + 16'(k);
      tick();
    end
    b_in_valid = 1'b0;
    b_rd(12'h404, d); chk("br_data1", d, 32'h00040054);
    b_rd(12'h40C, d); chk("br_data3", d, 32'h00060056);
    b_rd(12'h418, d); chk("br_data6", d, 32'h00030053);
    for (int j = 0; j < 8; j++) begin
      int rv;
      rv = ((j & 1) << 2) | (j & 2) | ((j >> 2) & 1);
      b_rd(12'h400 + 12'(4 * j), d);
      chk($sformatf("br_slot%0d", j), d, {16'(rv), 16'h0050 + 16'(rv)});
    end
    b_rd(12'h004, d); chk("br_status", d, 32'h00080002);
    b_rd(12'h420, d); chk("br_unmapped", d, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
